// File: rtl/ode_step_sequencer_pkg.sv
// Shared types and defaults for the ODE step sequencer: FSM state encoding
// and the default word width, multiplier latency and step-counter width.
package ode_pkg;

  localparam int DW_DEF      = 16;
  localparam int MUL_LAT_DEF = 3;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_U = 3'd1,
    S_MUL    = 3'd2,
    S_ACC    = 3'd3,
    S_CHECK  = 3'd4,
    S_OUT    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // A run owns the datapath in every state except IDLE.
  function automatic logic state_running(input state_t s);
    return s != S_IDLE;
  endfunction

endpackage

// File: rtl/ode_step_sequencer_if.sv
// Bundle of the sequencer's streaming ports (u in, x out) and the datapath
// operand/strobe/result signals.
interface ode_step_sequencer_if
  import ode_pkg::*;
#(
  parameter int DW = DW_DEF
);

  // Handshake rule for u_* and x_*: a word transfers on a rising edge where
  // valid and ready are both high; the producer holds valid and data stable
  // until that edge, and ready never depends on valid.
  logic [DW-1:0] u_data;
  logic          u_valid;
  logic          u_ready;

  logic [DW-1:0] ode_x;
  logic [DW-1:0] ode_u;
  logic          ode_en_mul;
  logic          ode_en_acc;
  logic [DW-1:0] ode_xnext;
  logic          ode_error;

  logic [DW-1:0] x_out;
  logic          x_valid;
  logic          x_ready;

  modport master (
    input  u_data, u_valid,
    output u_ready,
    output ode_x, ode_u, ode_en_mul, ode_en_acc,
    input  ode_xnext, ode_error,
    output x_out, x_valid,
    input  x_ready
  );

  modport slave (
    output u_data, u_valid,
    input  u_ready,
    input  ode_x, ode_u, ode_en_mul, ode_en_acc,
    output ode_xnext, ode_error,
    input  x_out, x_valid,
    output x_ready
  );

endinterface

// File: rtl/ode_seq_stream_out.sv
// Single-entry holding register for the new-state output stream: loaded once
// per successful step, held until the downstream consumer accepts it.
module ode_seq_stream_out
  import ode_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  output logic [DW-1:0] x_out,
  output logic          x_valid,
  input  logic          x_ready,
  output logic          accept
);

  assign accept = x_valid && x_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out   <= '0;
      x_valid <= 1'b0;
    end else if (load) begin
      x_out   <= load_data;
      x_valid <= 1'b1;
    end else if (accept) begin
      x_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ode_step_sequencer.sv
// Run controller for the Euler-step datapath: per step it pulls one u sample,
// strobes multiply then accumulate, commits the new state and streams it out.
module ode_step_sequencer
  import ode_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [DW-1:0]    x_init,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [CNT_W-1:0] step_cnt,
  ode_step_sequencer_if.master bus,
  output state_t           dbg_state
);

  // Counter only has to hold MUL_LAT-1.
  localparam int MCW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);

  state_t           state_q, state_d;
  logic [MCW-1:0]   mul_cnt_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] step_q;
  logic [DW-1:0]    x_q;
  logic [DW-1:0]    u_q;
  logic             busy_q, done_q, err_q;
  logic             u_ready_q, en_mul_q, en_acc_q;
  logic             start_acc, fire_u, commit, x_accept;

  assign start_acc = (state_q == S_IDLE) && start;
  assign fire_u    = (state_q == S_WAIT_U) && bus.u_valid;
  assign commit    = (state_q == S_CHECK) && !bus.ode_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_steps == '0) ? S_DONE : S_WAIT_U;
      S_WAIT_U: if (bus.u_valid) state_d = S_MUL;
      S_MUL:    if (mul_cnt_q == '0) state_d = S_ACC;
      S_ACC:    state_d = S_CHECK;
      S_CHECK:  state_d = bus.ode_error ? S_DONE : S_OUT;
      S_OUT:    if (x_accept) state_d = (step_q == num_q) ? S_DONE : S_WAIT_U;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt_q <= '0;
    end else if (fire_u) begin
      mul_cnt_q <= MCW'(MUL_LAT - 1);
    end else if ((state_q == S_MUL) && (mul_cnt_q != '0)) begin
      mul_cnt_q <= mul_cnt_q - 1'b1;
    end
  end

  // Run context: step target, committed state, sampled input and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q  <= '0;
      step_q <= '0;
      x_q    <= '0;
      u_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_acc) begin
        num_q  <= num_steps;
        x_q    <= x_init;
        step_q <= '0;
        err_q  <= 1'b0;
      end
      if (fire_u) u_q <= bus.u_data;
      if (state_q == S_CHECK) begin
        if (bus.ode_error) begin
          err_q <= 1'b1;
        end else begin
          x_q    <= bus.ode_xnext;
          step_q <= step_q + 1'b1;
        end
      end
    end
  end

  // Status and strobes come straight from flops, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      u_ready_q <= 1'b0;
      en_mul_q  <= 1'b0;
      en_acc_q  <= 1'b0;
    end else begin
      busy_q    <= state_running(state_d);
      done_q    <= (state_d == S_DONE);
      u_ready_q <= (state_d == S_WAIT_U);
      en_mul_q  <= (state_d == S_MUL);
      en_acc_q  <= (state_d == S_ACC);
    end
  end

  ode_seq_stream_out #(.DW(DW)) u_stream_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (commit),
    .load_data (bus.ode_xnext),
    .x_out     (bus.x_out),
    .x_valid   (bus.x_valid),
    .x_ready   (bus.x_ready),
    .accept    (x_accept)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_flag       = err_q;
  assign step_cnt       = step_q;
  assign bus.u_ready    = u_ready_q;
  assign bus.ode_x      = x_q;
  assign bus.ode_u      = u_q;
  assign bus.ode_en_mul = en_mul_q;
  assign bus.ode_en_acc = en_acc_q;
  assign dbg_state      = state_q;

endmodule
